// File: rtl/hash_slot_sched.sv
// -----------------------------------------------------------------------------
// hash_slot_sched
//
// Round-robin scheduler between the two-slot parameter-valid register and the
// hash core. When a slot reports valid parameters it is selected, the core is
// started with a one-cycle pulse, and the slot select / mode are held stable
// until the slot is released again with a one-cycle parameter-clear pulse.
// The release happens on core completion or on a watchdog timeout. A global
// hash clear aborts any job in flight.
//
// Parameters
//   TMO_CYC      watchdog limit in RUN cycles, 0 disables the watchdog
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   clr_hash     global hash clear (level), aborts any job
//   s0_prm_vld   slot 0 parameters valid
//   s0_flg_384   slot 0 mode (1 = SHA-384, 0 = SHA-256)
//   s1_prm_vld   slot 1 parameters valid
//   s1_flg_384   slot 1 mode
//   s0_prm_clr   one-cycle pulse releasing slot 0
//   s1_prm_clr   one-cycle pulse releasing slot 1
//   hash_start   one-cycle pulse starting the core
//   hash_sel     selected slot, stable from START through CLR
//   hash_384     mode of selected slot, stable from START through CLR
//   hash_done    core completion pulse
//   hash_abort   one-cycle pulse, core abandons the current job
//   sched_busy   scheduler is not idle
//   tmo_err      sticky watchdog error
// -----------------------------------------------------------------------------
module hash_slot_sched #(
    parameter int unsigned TMO_CYC = 32'd4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_hash,
    input  logic s0_prm_vld,
    input  logic s0_flg_384,
    input  logic s1_prm_vld,
    input  logic s1_flg_384,
    output logic s0_prm_clr,
    output logic s1_prm_clr,
    output logic hash_start,
    output logic hash_sel,
    output logic hash_384,
    input  logic hash_done,
    output logic hash_abort,
    output logic sched_busy,
    output logic tmo_err
);

    // Watchdog counter width: enough to hold TMO_CYC, never narrower than 1.
    localparam int CNT_RAW = $clog2(TMO_CYC + 32'd1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    // Counter value on the last permitted RUN cycle. Only meaningful when the
    // watchdog is enabled; the zero fallback keeps the constant in range.
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TMO_CYC > 32'd0) ? (TMO_CYC - 32'd1) : 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_CLR   = 2'd3
    } state_t;

    state_t           state_r;
    logic             last_r;      // slot that was started most recently
    logic [CNT_W-1:0] cnt_r;       // RUN cycles elapsed in the current job

    logic pick_vld_s;
    logic pick_slot_s;
    logic pick_384_s;
    logic tmo_hit_s;

    // Slot arbitration: a lone valid slot wins outright; on a tie the slot
    // that did not run last wins, so slots alternate under full load.
    always_comb begin
        pick_vld_s  = 1'b0;
        pick_slot_s = 1'b0;
        if (s0_prm_vld && s1_prm_vld) begin
            pick_vld_s  = 1'b1;
            pick_slot_s = ~last_r;
        end else if (s0_prm_vld) begin
            pick_vld_s  = 1'b1;
            pick_slot_s = 1'b0;
        end else if (s1_prm_vld) begin
            pick_vld_s  = 1'b1;
            pick_slot_s = 1'b1;
        end else begin
            pick_vld_s  = 1'b0;
            pick_slot_s = 1'b0;
        end
    end

    // Mode of the slot that arbitration picked.
    always_comb begin
        pick_384_s = 1'b0;
        if (pick_slot_s) begin
            pick_384_s = s1_flg_384;
        end else begin
            pick_384_s = s0_flg_384;
        end
    end

    // Watchdog expiry on the current RUN cycle.
    always_comb begin
        tmo_hit_s = 1'b0;
        if ((TMO_CYC != 32'd0) && (cnt_r == TMO_LAST)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Scheduler FSM with all outputs registered. Pulse outputs default low
    // each cycle and are raised on the transition into the state they mark,
    // so they are visible exactly during that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
            s0_prm_clr <= 1'b0;
            s1_prm_clr <= 1'b0;
            hash_start <= 1'b0;
            hash_sel   <= 1'b0;
            hash_384   <= 1'b0;
            hash_abort <= 1'b0;
            sched_busy <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            s0_prm_clr <= 1'b0;
            s1_prm_clr <= 1'b0;
            hash_start <= 1'b0;
            hash_abort <= 1'b0;

            if (clr_hash) begin
                // Global clear wins over every transition. Upstream clears
                // its own slots, so no release pulse is sent; the core only
                // needs telling if it was actually handed a job.
                state_r    <= ST_IDLE;
                sched_busy <= 1'b0;
                tmo_err    <= 1'b0;
                cnt_r      <= {CNT_W{1'b0}};
                hash_abort <= (state_r == ST_START) || (state_r == ST_RUN);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (pick_vld_s) begin
                            hash_sel   <= pick_slot_s;
                            hash_384   <= pick_384_s;
                            hash_start <= 1'b1;
                            sched_busy <= 1'b1;
                            state_r    <= ST_START;
                        end else begin
                            sched_busy <= 1'b0;
                            state_r    <= ST_IDLE;
                        end
                    end

                    ST_START: begin
                        cnt_r      <= {CNT_W{1'b0}};
                        last_r     <= hash_sel;
                        sched_busy <= 1'b1;
                        state_r    <= ST_RUN;
                    end

                    ST_RUN: begin
                        // A dropped valid on the running slot does not
                        // matter here: the job always finishes with a release.
                        if (hash_done) begin
                            s0_prm_clr <= ~hash_sel;
                            s1_prm_clr <= hash_sel;
                            sched_busy <= 1'b1;
                            state_r    <= ST_CLR;
                        end else if (tmo_hit_s) begin
                            tmo_err    <= 1'b1;
                            s0_prm_clr <= ~hash_sel;
                            s1_prm_clr <= hash_sel;
                            sched_busy <= 1'b1;
                            state_r    <= ST_CLR;
                        end else begin
                            cnt_r      <= cnt_r + CNT_W'(1);
                            sched_busy <= 1'b1;
                            state_r    <= ST_RUN;
                        end
                    end

                    ST_CLR: begin
                        // Upstream drops the released valid on this edge, so
                        // IDLE cannot pick the same slot up again.
                        sched_busy <= 1'b0;
                        state_r    <= ST_IDLE;
                    end

                    default: begin
                        sched_busy <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
